// File: rtl/alu_result_collector_if.sv
// Handshake bundle between the ALU result producer, the collector and the downstream consumer.
// The collector takes the slave view; the producer/consumer side takes the master view.
interface alu_result_collector_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_sel;
  logic [2:0] out_flags;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_flags
  );
endinterface

// File: rtl/alu_result_collector.sv
// Collects ALU results with their selector and {P,N,Z} flags into a small FIFO, and keeps
// a saturating running sum plus a wrapping result counter for on-chip self-check.
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_result_collector_if.slave    bus,
  input  logic                     clr,
  output logic [ACC_W-1:0]         acc,
  output logic                     acc_sat,
  output logic [7:0]               res_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = 14;

  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  // Flags in {P,N,Z} order: odd parity, sign bit, zero.
  function automatic logic [2:0] flags_of(input logic [7:0] d);
    return {^d, d[7], ~|d};
  endfunction

  // Returns {overflowed, saturated_sum}. One extra bit is enough to see overflow
  // because an 8-bit addend can never carry twice into an ACC_W >= 9 accumulator.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       d);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W-7){1'b0}}, d};
    if (sum[ACC_W]) begin
      return {1'b1, ACC_MAX};
    end
    return sum;
  endfunction

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        level_q;

  logic               push;
  logic               pop;
  logic               vld_p1;
  logic [ENTRY_W-1:0] entry_p0;
  logic [ENTRY_W-1:0] head_p1;
  logic               acc_ovf_p0;
  logic [ACC_W-1:0]   acc_sum_p0;

  // ---- stage p0: incoming result, flag generation and accumulator candidate ----
  assign bus.in_ready = (level_q != LVL_FULL);
  assign push         = bus.in_valid & bus.in_ready;
  assign entry_p0     = {bus.in_data, bus.in_sel, flags_of(bus.in_data)};
  assign {acc_ovf_p0, acc_sum_p0} = sat_add(acc, bus.in_data);

  // Entry storage carries data only, so it is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_ONE;
      end else if (pop && !push) begin
        level_q <= level_q - LVL_ONE;
      end
    end
  end

  // clr wins over a same-cycle accept for the statistics, but never blocks the FIFO write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc       <= '0;
      acc_sat   <= 1'b0;
      res_count <= '0;
    end else if (push) begin
      acc       <= acc_sum_p0;
      acc_sat   <= acc_sat | acc_ovf_p0;
      res_count <= res_count + 8'd1;
    end
  end

  // ---- stage p1: registered head entry presented to the consumer ----
  assign vld_p1        = (level_q != '0);
  assign pop           = vld_p1 & bus.out_ready;
  assign head_p1       = mem[rd_ptr];
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = vld_p1 ? head_p1[13:6] : 8'd0;
  assign bus.out_sel   = vld_p1 ? head_p1[5:3]  : 3'd0;
  assign bus.out_flags = vld_p1 ? head_p1[2:0]  : 3'd0;
  assign level         = level_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: a queue-based reference model fed at each
// accept, and a negedge monitor that compares every visible output against it.
module tb_alu_result_collector;
  localparam int DEPTH   = 4;
  localparam int ACC_W   = 12;
  localparam int ACC_MAX = 4095;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic [ACC_W-1:0] acc;
  logic             acc_sat;
  logic [7:0]       res_count;
  logic [2:0]       level;

  alu_result_collector_if bus();

  alu_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr(clr),
    .acc(acc), .acc_sat(acc_sat), .res_count(res_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  int   m_acc = 0;
  bit   m_sat = 1'b0;
  int   m_cnt = 0;
  int   snap  = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_flags(input logic [7:0] d);
    int p, n, z;
    p = ($countones(d) % 2 == 1) ? 1 : 0;
    n = (int'(d) >= 128) ? 1 : 0;
    z = (int'(d) == 0) ? 1 : 0;
    return p * 4 + n * 2 + z;
  endfunction

  // Reference model: occupancy comes from the queue length seen before this edge's pop.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_acc = 0;
      m_sat = 1'b0;
      m_cnt = 0;
    end else begin
      if (bus.in_valid && snap < DEPTH) begin
        q.push_back('{d: bus.in_data, s: bus.in_sel});
        if (!clr) begin
          m_cnt = (m_cnt + 1) % 256;
          if (m_acc + int'(bus.in_data) > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_sat = 1'b1;
          end else begin
            m_acc = m_acc + int'(bus.in_data);
          end
        end
      end
      if (clr) begin
        m_acc = 0;
        m_sat = 1'b0;
        m_cnt = 0;
      end
    end
  end

  // Monitor: compare outputs mid-cycle, then retire the head if the consumer takes it.
  always @(negedge clk) begin
    snap = q.size();
    if (mon_en) begin
      check("out_valid", int'(bus.out_valid), int'(q.size() != 0));
      check("in_ready",  int'(bus.in_ready),  int'(q.size() != DEPTH));
      check("level",     int'(level),         q.size());
      check("acc",       int'(acc),           m_acc);
      check("acc_sat",   int'(acc_sat),       int'(m_sat));
      check("res_count", int'(res_count),     m_cnt);
      if (q.size() != 0) begin
        check("out_data",  int'(bus.out_data),  int'(q[0].d));
        check("out_sel",   int'(bus.out_sel),   int'(q[0].s));
        check("out_flags", int'(bus.out_flags), exp_flags(q[0].d));
      end else begin
        check("empty_out", int'({bus.out_data, bus.out_sel, bus.out_flags}), 0);
      end
    end
    if (q.size() != 0 && bus.out_ready && !rst) begin
      void'(q.pop_front());
    end
  end

  task automatic cyc(input bit iv, input logic [7:0] d, input logic [2:0] s,
                     input bit ordy, input bit c, input bit r);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_sel    = s;
    bus.out_ready = ordy;
    clr           = c;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_sel = 3'd0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    cyc(0, 8'h00, 3'd0, 0, 0, 1);
    cyc(0, 8'h00, 3'd0, 0, 0, 0);
    check("rst_in_ready",  int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_level",     int'(level), 0);
    check("rst_acc",       int'(acc), 0);
    check("rst_res_count", int'(res_count), 0);

    // Two entries, then pop both
    cyc(1, 8'h00, 3'd3, 0, 0, 0);
    check("first_valid", int'(bus.out_valid), 1);
    cyc(1, 8'h81, 3'd5, 0, 0, 0);
    check("head0_data",  int'(bus.out_data), 'h00);
    check("head0_sel",   int'(bus.out_sel), 3);
    check("head0_flags", int'(bus.out_flags), 'b001);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    check("head1_data",  int'(bus.out_data), 'h81);
    check("head1_sel",   int'(bus.out_sel), 5);
    check("head1_flags", int'(bus.out_flags), 'b010);
    check("acc_81",      int'(acc), 'h081);
    check("count_2",     int'(res_count), 2);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    check("drained", int'(level), 0);

    // Fill to full, reject a fifth, drain in order, refill across the wrap
    cyc(0, 8'h00, 3'd0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 3'(i), 0, 0, 0);
    check("full_in_ready", int'(bus.in_ready), 0);
    check("full_level",    int'(level), 4);
    cyc(1, 8'h55, 3'd1, 0, 0, 0);
    check("reject_level", int'(level), 4);
    check("reject_acc",   int'(acc), 10);
    for (int i = 1; i <= 4; i++) begin
      check("fill_order", int'(bus.out_data), i);
      cyc(0, 8'h00, 3'd0, 1, 0, 0);
    end
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h10 + i), 3'(i), 0, 0, 0);
    check("wrap_head", int'(bus.out_data), 'h10);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 3'd0, 1, 0, 0);

    // Steady push+pop at level 2
    cyc(1, 8'hA0, 3'd2, 0, 0, 0);
    cyc(1, 8'hA1, 3'd4, 0, 0, 0);
    c0 = int'(res_count);
    for (int i = 0; i < 10; i++) cyc(1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1, 0, 0);
    check("steady_level", int'(level), 2);
    check("steady_count", int'(res_count), (c0 + 10) % 256);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 3'd0, 1, 0, 0);

    // Saturation and clr leaving the FIFO alone
    cyc(0, 8'h00, 3'd0, 0, 1, 0);
    for (int i = 1; i <= 17; i++) begin
      cyc(1, 8'hFF, 3'd7, 1, 0, 0);
      if (i == 16) begin
        check("acc_4080", int'(acc), 4080);
        check("sat_16",   int'(acc_sat), 0);
      end
    end
    check("acc_4095", int'(acc), ACC_MAX);
    check("sat_17",   int'(acc_sat), 1);
    cyc(1, 8'h11, 3'd1, 0, 0, 0);
    cyc(1, 8'h22, 3'd2, 0, 0, 0);
    check("sat_hold", int'(acc), ACC_MAX);
    cyc(0, 8'h00, 3'd0, 0, 1, 0);
    check("clr_acc",   int'(acc), 0);
    check("clr_sat",   int'(acc_sat), 0);
    check("clr_count", int'(res_count), 0);
    check("clr_level", int'(level), 3);
    check("clr_head",  int'(bus.out_data), 'hFF);

    // Reset with three entries buffered
    cyc(0, 8'h00, 3'd0, 0, 0, 1);
    check("rst_mid_level", int'(level), 0);
    check("rst_mid_valid", int'(bus.out_valid), 0);
    cyc(1, 8'h3C, 3'd2, 0, 0, 0);
    cyc(1, 8'hC3, 3'd6, 0, 0, 0);
    check("post_rst_head", int'(bus.out_data), 'h3C);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);
    check("post_rst_next", int'(bus.out_data), 'hC3);
    cyc(0, 8'h00, 3'd0, 1, 0, 0);

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
          3'($urandom_range(0, 7)),
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 63) == 0,
          $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 8'h00, 3'd0, 1, 0, 0);
    check("final_level", int'(level), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
